// File: rtl/dcom_buffer_wr_arbiter_if.sv
// Requester-side and dcom data-buffer-side signals of the buffer write arbiter.
// The arbiter uses the slave view; the environment uses the master view.
interface dcom_buffer_wr_arbiter_if #(
    parameter int G_NUM_REQ = 4,
    parameter int G_ADDR_W  = 12,
    parameter int G_DATA_W  = 64,
    parameter int G_BE_W    = 8
);
    logic [G_NUM_REQ-1:0]          req_write_i;
    logic [G_NUM_REQ-1:0]          req_last_i;
    logic [G_NUM_REQ*G_ADDR_W-1:0] req_address_i;
    logic [G_NUM_REQ*G_DATA_W-1:0] req_writedata_i;
    logic [G_NUM_REQ*G_BE_W-1:0]   req_byteenable_i;
    logic [G_NUM_REQ-1:0]          req_waitrequest_o;
    logic [G_ADDR_W-1:0]           buf_address_o;
    logic                          buf_write_o;
    logic [G_DATA_W-1:0]           buf_writedata_o;
    logic [G_BE_W-1:0]             buf_byteenable_o;
    logic                          buf_waitrequest_i;
    logic [G_NUM_REQ-1:0]          grant_o;
    logic                          busy_o;
    logic                          timeout_o;

    modport slave (
        input  req_write_i, req_last_i, req_address_i, req_writedata_i, req_byteenable_i,
        input  buf_waitrequest_i,
        output req_waitrequest_o, buf_address_o, buf_write_o, buf_writedata_o, buf_byteenable_o,
        output grant_o, busy_o, timeout_o
    );

    modport master (
        output req_write_i, req_last_i, req_address_i, req_writedata_i, req_byteenable_i,
        output buf_waitrequest_i,
        input  req_waitrequest_o, buf_address_o, buf_write_o, buf_writedata_o, buf_byteenable_o,
        input  grant_o, busy_o, timeout_o
    );
endinterface

// File: rtl/dcom_buffer_wr_arbiter.sv
// Round-robin arbiter sharing the dcom data-buffer write slave between several
// Avalon-MM write masters, with a per-grant burst cap and an idle-owner timeout.
module dcom_buffer_wr_arbiter #(
    parameter int G_NUM_REQ      = 4,
    parameter int G_ADDR_W       = 12,
    parameter int G_DATA_W       = 64,
    parameter int G_BE_W         = 8,
    parameter int G_MAX_BURST    = 16,
    parameter int G_IDLE_TIMEOUT = 32
) (
    input logic clock_sink_clk,
    input logic reset_sink_reset,
    dcom_buffer_wr_arbiter_if.slave bus
);
    localparam int PTR_W = (G_NUM_REQ > 1) ? $clog2(G_NUM_REQ) : 1;

    typedef enum logic {S_IDLE, S_OWN} state_t;

    state_t               state_reg;
    logic [G_NUM_REQ-1:0] grant_reg;
    logic [PTR_W-1:0]     owner_reg;
    logic [PTR_W-1:0]     rr_ptr_reg;
    logic [7:0]           word_cnt_reg;
    logic [7:0]           idle_cnt_reg;
    logic                 timeout_reg;

    logic [G_ADDR_W-1:0]  req_addr [G_NUM_REQ];
    logic [G_DATA_W-1:0]  req_data [G_NUM_REQ];
    logic [G_BE_W-1:0]    req_be   [G_NUM_REQ];
    logic [PTR_W-1:0]     cand_idx [G_NUM_REQ];

    logic                 own;
    logic                 own_write;
    logic                 accept;
    logic                 last_hit;
    logic                 burst_hit;
    logic                 idle_hit;
    logic                 release_now;
    logic                 pick_valid;
    logic [PTR_W-1:0]     pick_idx;
    logic [PTR_W-1:0]     rr_ptr_next;

    // cand_idx[i] is the requester examined at circular offset i from rr_ptr
    for (genvar gi = 0; gi < G_NUM_REQ; gi++) begin : g_req
        assign req_addr[gi] = bus.req_address_i[gi*G_ADDR_W +: G_ADDR_W];
        assign req_data[gi] = bus.req_writedata_i[gi*G_DATA_W +: G_DATA_W];
        assign req_be[gi]   = bus.req_byteenable_i[gi*G_BE_W +: G_BE_W];
        assign cand_idx[gi] = PTR_W'((int'(rr_ptr_reg) + gi) % G_NUM_REQ);
        assign bus.req_waitrequest_o[gi] =
            (own && owner_reg == PTR_W'(gi)) ? bus.buf_waitrequest_i : 1'b1;
    end

    // Scan from the far end so the smallest offset with a request wins
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = G_NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_write_i[cand_idx[i]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx[i];
            end
        end
    end

    assign own         = (state_reg == S_OWN);
    assign own_write   = bus.req_write_i[owner_reg];
    assign accept      = own && own_write && !bus.buf_waitrequest_i;
    assign last_hit    = accept && bus.req_last_i[owner_reg];
    assign burst_hit   = accept && (word_cnt_reg == 8'(G_MAX_BURST - 1));
    assign idle_hit    = own && !own_write && (idle_cnt_reg == 8'(G_IDLE_TIMEOUT - 1));
    assign release_now = last_hit || burst_hit || idle_hit;
    assign rr_ptr_next = (owner_reg == PTR_W'(G_NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;

    assign bus.buf_write_o      = own && own_write;
    assign bus.buf_address_o    = req_addr[owner_reg];
    assign bus.buf_writedata_o  = req_data[owner_reg];
    assign bus.buf_byteenable_o = req_be[owner_reg];
    assign bus.grant_o          = grant_reg;
    assign bus.busy_o           = own;
    assign bus.timeout_o        = timeout_reg;

    always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
        if (reset_sink_reset) begin
            state_reg    <= S_IDLE;
            grant_reg    <= '0;
            owner_reg    <= '0;
            rr_ptr_reg   <= '0;
            word_cnt_reg <= '0;
            idle_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (pick_valid) begin
                        state_reg    <= S_OWN;
                        owner_reg    <= pick_idx;
                        grant_reg    <= {{(G_NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        word_cnt_reg <= '0;
                        idle_cnt_reg <= '0;
                    end
                end
                default: begin
                    if (accept && word_cnt_reg != 8'(G_MAX_BURST))
                        word_cnt_reg <= word_cnt_reg + 8'd1;
                    if (own_write)
                        idle_cnt_reg <= '0;
                    else if (idle_cnt_reg != 8'(G_IDLE_TIMEOUT))
                        idle_cnt_reg <= idle_cnt_reg + 8'd1;
                    // Forced and timeout releases leave the requester unaware; it simply re-arbitrates
                    if (release_now) begin
                        state_reg    <= S_IDLE;
                        grant_reg    <= '0;
                        rr_ptr_reg   <= rr_ptr_next;
                        word_cnt_reg <= '0;
                        idle_cnt_reg <= '0;
                        timeout_reg  <= idle_hit;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dcom_buffer_wr_arbiter.sv
// Directed bench for the dcom buffer write arbiter: round-robin order, burst cap,
// slave backpressure, idle timeout and asynchronous reset mid-burst.
module tb_dcom_buffer_wr_arbiter;
    localparam int NR = 4;
    localparam int AW = 12;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int MW = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcom_buffer_wr_arbiter_if #(.G_NUM_REQ(NR), .G_ADDR_W(AW), .G_DATA_W(DW), .G_BE_W(BW)) bus ();

    dcom_buffer_wr_arbiter #(
        .G_NUM_REQ(NR), .G_ADDR_W(AW), .G_DATA_W(DW), .G_BE_W(BW),
        .G_MAX_BURST(16), .G_IDLE_TIMEOUT(32)
    ) dut (
        .clock_sink_clk   (clk),
        .reset_sink_reset (rst),
        .bus              (bus)
    );

    int tests  = 0;
    int failed = 0;

    // Per-requester word programs; pos advances when the arbiter accepts a word
    logic [AW-1:0] prog_addr [NR][MW];
    logic [DW-1:0] prog_data [NR][MW];
    logic          prog_last [NR][MW];
    int            plen [NR];
    int            pos  [NR];

    int            log_n;
    int            log_req  [64];
    logic [AW-1:0] log_addr [64];
    logic [DW-1:0] log_data [64];

    int            tc;
    logic [NR-1:0] gtr [64];
    logic          ttr [64];

    function automatic logic [DW-1:0] word_data(input int k, input int i);
        return 64'hA5A5_0000_0000_0000 | (64'(k) << 32) | 64'(i);
    endfunction

    function automatic int oh2idx(input logic [NR-1:0] g);
        for (int k = 0; k < NR; k++) if (g[k]) return k;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        tests++;
        assert (obs === want) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic load(input int k, input int n, input logic [AW-1:0] base, input logic with_last);
        for (int i = 0; i < n; i++) begin
            prog_addr[k][i] = base + AW'(i);
            prog_data[k][i] = word_data(k, i);
            prog_last[k][i] = with_last && (i == n - 1);
        end
        plen[k] = n;
        pos[k]  = 0;
    endtask

    task automatic drive();
        for (int k = 0; k < NR; k++) begin
            if (pos[k] < plen[k]) begin
                bus.req_write_i[k]                 = 1'b1;
                bus.req_last_i[k]                  = prog_last[k][pos[k]];
                bus.req_address_i[k*AW +: AW]      = prog_addr[k][pos[k]];
                bus.req_writedata_i[k*DW +: DW]    = prog_data[k][pos[k]];
                bus.req_byteenable_i[k*BW +: BW]   = 8'hF0 + 8'(k);
            end else begin
                bus.req_write_i[k] = 1'b0;
                bus.req_last_i[k]  = 1'b0;
            end
        end
    endtask

    task automatic start();
        tc      = 0;
        gtr[0]  = bus.grant_o;
        ttr[0]  = bus.timeout_o;
        log_n   = 0;
    endtask

    // One clock: log the word accepted at the coming edge, then present new inputs
    task automatic cyc();
        int o;
        o = oh2idx(bus.grant_o);
        if (bus.buf_write_o && !bus.buf_waitrequest_i && o >= 0) begin
            log_req[log_n]  = o;
            log_addr[log_n] = bus.buf_address_o;
            log_data[log_n] = bus.buf_writedata_o;
            log_n++;
            pos[o]++;
        end
        @(posedge clk);
        #1;
        drive();
        #1;
        if (tc < 63) begin
            tc++;
            gtr[tc] = bus.grant_o;
            ttr[tc] = bus.timeout_o;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] s2_exp [11];
        int ones;
        s2_exp = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};

        rst = 1'b1;
        bus.buf_waitrequest_i = 1'b0;
        bus.req_write_i       = '0;
        bus.req_last_i        = '0;
        bus.req_address_i     = '0;
        bus.req_writedata_i   = '0;
        bus.req_byteenable_i  = '0;
        for (int k = 0; k < NR; k++) begin
            plen[k] = 0;
            pos[k]  = 0;
        end
        log_n = 0;
        tc    = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant",   64'(bus.grant_o), 64'h0);
        chk("rst_busy",    64'(bus.busy_o), 64'h0);
        chk("rst_write",   64'(bus.buf_write_o), 64'h0);
        chk("rst_wait",    64'(bus.req_waitrequest_o), 64'hF);
        chk("rst_timeout", 64'(bus.timeout_o), 64'h0);
        #1 rst = 1'b0;

        // Requester 0 alone, 3 words
        load(0, 3, 12'h010, 1'b1); drive(); #1; start();
        chk("s1_idle_write", 64'(bus.buf_write_o), 64'h0);
        chk("s1_idle_wait",  64'(bus.req_waitrequest_o), 64'hF);
        cyc();
        chk("s1_grant", 64'(bus.grant_o), 64'h1);
        chk("s1_busy",  64'(bus.busy_o), 64'h1);
        chk("s1_write", 64'(bus.buf_write_o), 64'h1);
        chk("s1_addr0", 64'(bus.buf_address_o), 64'h010);
        chk("s1_data0", bus.buf_writedata_o, word_data(0, 0));
        chk("s1_be",    64'(bus.buf_byteenable_o), 64'hF0);
        chk("s1_wait",  64'(bus.req_waitrequest_o), 64'hE);
        cyc();
        chk("s1_addr1", 64'(bus.buf_address_o), 64'h011);
        cyc();
        chk("s1_addr2", 64'(bus.buf_address_o), 64'h012);
        cyc();
        chk("s1_rel_grant", 64'(bus.grant_o), 64'h0);
        chk("s1_rel_busy",  64'(bus.busy_o), 64'h0);
        chk("s1_words",     64'(log_n), 64'd3);
        chk("s1_log_addr",  64'(log_addr[2]), 64'h012);
        chk("s1_log_data",  log_data[2], word_data(0, 2));

        // rr_ptr now 1: simultaneous req0/req1 serves req1 first
        load(0, 1, 12'h020, 1'b1); load(1, 1, 12'h030, 1'b1); drive(); #1; start();
        repeat (4) cyc();
        chk("s1b_g1", 64'(gtr[1]), 64'h2);
        chk("s1b_g2", 64'(gtr[2]), 64'h0);
        chk("s1b_g3", 64'(gtr[3]), 64'h1);
        chk("s1b_g4", 64'(gtr[4]), 64'h0);
        chk("s1b_first_addr", 64'(log_addr[0]), 64'h030);

        rst = 1'b1; #1; rst = 1'b0;

        // req0 and req2 together, then req0 and req3 together
        load(0, 2, 12'h100, 1'b1); load(2, 2, 12'h200, 1'b1); drive(); #1; start();
        repeat (6) cyc();
        load(0, 1, 12'h110, 1'b1); load(3, 1, 12'h310, 1'b1); drive(); #1;
        repeat (4) cyc();
        for (int i = 0; i < 11; i++)
            chk($sformatf("s2_grant_c%0d", i), 64'(gtr[i]), 64'(s2_exp[i]));
        chk("s2_log3_req",  64'(log_req[3]), 64'd2);
        chk("s2_log4_addr", 64'(log_addr[4]), 64'h310);
        chk("s2_log5_addr", 64'(log_addr[5]), 64'h110);

        // req1 streams 20 words while req3 waits: capped at 16 per grant
        load(1, 20, 12'h400, 1'b1); load(3, 2, 12'h500, 1'b1); drive(); #1; start();
        repeat (25) cyc();
        chk("s3_g1",  64'(gtr[1]),  64'h2);
        chk("s3_g16", 64'(gtr[16]), 64'h2);
        chk("s3_g17", 64'(gtr[17]), 64'h0);
        chk("s3_g18", 64'(gtr[18]), 64'h8);
        chk("s3_g20", 64'(gtr[20]), 64'h0);
        chk("s3_g21", 64'(gtr[21]), 64'h2);
        chk("s3_g25", 64'(gtr[25]), 64'h0);
        chk("s3_words",    64'(log_n), 64'd22);
        chk("s3_w15_addr", 64'(log_addr[15]), 64'h40F);
        chk("s3_w16_req",  64'(log_req[16]), 64'd3);
        chk("s3_resume_addr", 64'(log_addr[18]), 64'h410);
        chk("s3_resume_data", log_data[18], word_data(1, 16));
        chk("s3_tail_addr",   64'(log_addr[21]), 64'h413);

        // Slave backpressure for 5 cycles in the middle of req2's burst
        load(2, 4, 12'h600, 1'b1); drive(); #1; start();
        repeat (2) cyc();
        bus.buf_waitrequest_i = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("s4_wait_c%0d", i), 64'(bus.req_waitrequest_o), 64'hF);
            chk($sformatf("s4_addr_c%0d", i), 64'(bus.buf_address_o), 64'h601);
            chk($sformatf("s4_data_c%0d", i), bus.buf_writedata_o, word_data(2, 1));
            cyc();
        end
        chk("s4_no_accept", 64'(log_n), 64'd1);
        bus.buf_waitrequest_i = 1'b0; #1;
        chk("s4_wait_owner", 64'(bus.req_waitrequest_o), 64'hB);
        repeat (3) cyc();
        chk("s4_rel_grant", 64'(bus.grant_o), 64'h0);
        chk("s4_words",     64'(log_n), 64'd4);
        chk("s4_w3_addr",   64'(log_addr[3]), 64'h603);

        // req0 goes idle after 2 words without last; req1 waits
        load(0, 2, 12'h700, 1'b0); load(1, 1, 12'h7F0, 1'b1); drive(); #1; start();
        repeat (37) cyc();
        chk("s5_g1",  64'(gtr[1]),  64'h1);
        chk("s5_g34", 64'(gtr[34]), 64'h1);
        chk("s5_g35", 64'(gtr[35]), 64'h0);
        chk("s5_g36", 64'(gtr[36]), 64'h2);
        chk("s5_to34", 64'(ttr[34]), 64'h0);
        chk("s5_to35", 64'(ttr[35]), 64'h1);
        ones = 0;
        for (int i = 0; i <= 37; i++) ones += int'(ttr[i]);
        chk("s5_to_pulses", 64'(ones), 64'd1);
        chk("s5_words",     64'(log_n), 64'd3);

        // Reset during word 5 of a 10-word burst
        load(1, 10, 12'h800, 1'b1); drive(); #1; start();
        repeat (5) cyc();
        chk("s6_pre_addr",  64'(bus.buf_address_o), 64'h804);
        chk("s6_pre_grant", 64'(bus.grant_o), 64'h2);
        rst = 1'b1; #1;
        chk("s6_rst_grant", 64'(bus.grant_o), 64'h0);
        chk("s6_rst_busy",  64'(bus.busy_o), 64'h0);
        chk("s6_rst_write", 64'(bus.buf_write_o), 64'h0);
        chk("s6_rst_wait",  64'(bus.req_waitrequest_o), 64'hF);
        chk("s6_rst_words", 64'(log_n), 64'd4);
        for (int k = 0; k < NR; k++) plen[k] = 0;
        load(2, 1, 12'h900, 1'b1); drive(); #1;
        rst = 1'b0; #1; start();
        chk("s6_idle_grant", 64'(bus.grant_o), 64'h0);
        cyc();
        chk("s6_grant", 64'(bus.grant_o), 64'h4);
        chk("s6_addr",  64'(bus.buf_address_o), 64'h900);
        cyc();
        chk("s6_rel_grant", 64'(bus.grant_o), 64'h0);
        chk("s6_words",     64'(log_n), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
